sr_flip_flop: RTL and testbench

SR_FLIP_FLOP -- requirements
Module: sr_flip_flop

---
 rtl/sr_flip_flop.sv | 77 +++++++
 tb/tb_sr_flip_flop.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sr_flip_flop.sv
// ---------------------------------------------------------------------------
// sr_flip_flop
//
// Bank of WIDTH independent, clocked SR storage cells. Every bit samples its
// own set/reset request on the rising edge of clk and updates one cycle
// later. There is no combinational path from S/R to Q.
//
// Parameters
//   WIDTH      number of independent bit cells (1..64)
//   BOTH_MODE  policy when S=R=1 on a bit: 0 = hold, 1 = set wins,
//              2 = reset wins, any other value behaves as hold
//
// Ports (declared in positional order S, R, clk, Q, rst_n, Qn, invalid)
//   S        in   WIDTH  per-bit set request
//   R        in   WIDTH  per-bit reset request
//   clk      in   1      rising-edge clock
//   Q        out  WIDTH  registered cell state
//   rst_n    in   1      synchronous active-low reset, priority over S/R
//   Qn       out  WIDTH  bitwise complement of Q
//   invalid  out  WIDTH  registered flag: S=R=1 was sampled on the last edge
// ---------------------------------------------------------------------------
module sr_flip_flop #(
    parameter int WIDTH     = 1,
    parameter int BOTH_MODE = 0
) (
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             clk,
    output logic [WIDTH-1:0] Q,
    input  logic             rst_n,
    output logic [WIDTH-1:0] Qn,
    output logic [WIDTH-1:0] invalid
);

    // Out-of-range policy values collapse onto "hold".
    localparam int MODE = ((BOTH_MODE == 1) || (BOTH_MODE == 2)) ? BOTH_MODE : 0;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] invalid_q;
    logic [WIDTH-1:0] invalid_d;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic both_val;

            // Value taken when S and R are both asserted on this bit.
            assign both_val = (MODE == 1) ? 1'b1 :
                              (MODE == 2) ? 1'b0 : q_q[gi];

            // Written as a sum of products rather than an if/case so that an
            // X on S or R propagates to this bit instead of silently picking
            // a branch; other bits are untouched.
            assign q_d[gi] = (S[gi] & ~R[gi])
                           | (~S[gi] & ~R[gi] & q_q[gi])
                           | (S[gi] & R[gi] & both_val);

            assign invalid_d[gi] = S[gi] & R[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q       <= '0;
            invalid_q <= '0;
        end else begin
            q_q       <= q_d;
            invalid_q <= invalid_d;
        end
    end

    assign Q       = q_q;
    assign Qn      = ~q_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_sr_flip_flop.sv
// ---------------------------------------------------------------------------
// tb_sr_flip_flop
//
// Directed bench for sr_flip_flop. Four 1-bit instances (BOTH_MODE 0..3)
// share one S/R stimulus so the S=R=1 policies can be compared side by side;
// a 4-bit BOTH_MODE=0 instance exercises per-bit independence. Inputs change
// 2 time units after the falling edge; outputs are sampled 1 unit after the
// rising edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_sr_flip_flop;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:0] s1, r1;
    logic [3:0] s4, r4;

    logic [0:0] q_m0, qn_m0, inv_m0;
    logic [0:0] q_m1, qn_m1, inv_m1;
    logic [0:0] q_m2, qn_m2, inv_m2;
    logic [0:0] q_m3, qn_m3, inv_m3;
    logic [3:0] q_w4, qn_w4, inv_w4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr_flip_flop #(.WIDTH(1), .BOTH_MODE(0)) u_m0 (
        .S(s1), .R(r1), .clk(clk), .Q(q_m0), .rst_n(rst_n), .Qn(qn_m0), .invalid(inv_m0));
    sr_flip_flop #(.WIDTH(1), .BOTH_MODE(1)) u_m1 (
        .S(s1), .R(r1), .clk(clk), .Q(q_m1), .rst_n(rst_n), .Qn(qn_m1), .invalid(inv_m1));
    sr_flip_flop #(.WIDTH(1), .BOTH_MODE(2)) u_m2 (
        .S(s1), .R(r1), .clk(clk), .Q(q_m2), .rst_n(rst_n), .Qn(qn_m2), .invalid(inv_m2));
    sr_flip_flop #(.WIDTH(1), .BOTH_MODE(3)) u_m3 (
        .S(s1), .R(r1), .clk(clk), .Q(q_m3), .rst_n(rst_n), .Qn(qn_m3), .invalid(inv_m3));
    sr_flip_flop #(.WIDTH(4), .BOTH_MODE(0)) u_w4 (
        .S(s4), .R(r4), .clk(clk), .Q(q_w4), .rst_n(rst_n), .Qn(qn_w4), .invalid(inv_w4));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs in the low phase, then sample just after the edge.
    task automatic step(input logic rst, input logic s, input logic r,
                        input logic [3:0] sw, input logic [3:0] rw);
        @(negedge clk);
        #2;
        rst_n = rst;
        s1    = s;
        r1    = r;
        s4    = sw;
        r4    = rw;
        @(posedge clk);
        #1;
        $display("step rst_n=%b S=%b R=%b | Q m0..m3=%b%b%b%b inv m0=%b | S4=%b R4=%b Q4=%b inv4=%b",
                 rst, s, r, q_m0, q_m1, q_m2, q_m3, inv_m0, sw, rw, q_w4, inv_w4);
    endtask

    initial begin
        rst_n = 1'b0;
        s1 = 1'b0; r1 = 1'b0; s4 = 4'h0; r4 = 4'h0;

        // Reset edge with S asserted: reset wins.
        step(1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
        check("rst_q",    q_m0,   0);
        check("rst_qn",   qn_m0,  1);
        check("rst_inv",  inv_m0, 0);
        check("rst_q4",   q_w4,   4'h0);
        check("rst_qn4",  qn_w4,  4'hF);

        // Basic sequence; first edge after release evaluates normally.
        step(1'b1, 1'b0, 1'b1, 4'h0, 4'h0); check("seq1_q", q_m0, 0);
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0); check("seq2_q", q_m0, 1);
        check("seq2_qn", qn_m0, 0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0); check("seq3_q", q_m0, 1);
        step(1'b1, 1'b0, 1'b1, 4'h0, 4'h0); check("seq4_q", q_m0, 0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0); check("seq5_q", q_m0, 0);

        // Forbidden input from Q=1.
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0); check("pre_both_q", q_m2, 1);
        step(1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
        check("both1_m0_q",   q_m0,   1);
        check("both1_m0_inv", inv_m0, 1);
        check("both1_m1_q",   q_m1,   1);
        check("both1_m2_q",   q_m2,   0);
        check("both1_m2_qn",  qn_m2,  1);
        check("both1_m3_q",   q_m3,   1);
        check("both1_m2_inv", inv_m2, 1);
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        check("both1_clr_inv", inv_m0, 0);
        check("both1_hold_m2", q_m2,   0);

        // Forbidden input from Q=0: only set-wins changes.
        step(1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
        check("both0_m0_q", q_m0, 0);
        check("both0_m1_q", q_m1, 1);
        check("both0_m3_q", q_m3, 0);
        check("both0_m1_inv", inv_m1, 1);

        // Reset mid-operation, including priority over S=R=1.
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0); check("mid_set_q", q_m0, 1);
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0); check("mid_rst_q", q_m0, 0);
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0); check("mid_rel_q", q_m0, 1);
        step(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
        check("rst_both_m1_q",   q_m1,   0);
        check("rst_both_m0_inv", inv_m0, 0);
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0); check("rel2_q", q_m1, 1);

        // Short rst_n pulse between edges must not clear Q.
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        $display("rst_n glitch between edges | Q m0=%b", q_m0);
        check("rst_glitch_q", q_m0, 1);

        // Sub-period S pulse between edges: no latching, no comb path.
        step(1'b1, 1'b0, 1'b1, 4'h0, 4'h0); check("pulse_pre_q", q_m0, 0);
        r1 = 1'b0;
        #1 s1 = 1'b1;
        #2 check("pulse_mid_q", q_m0, 0);
        #2 s1 = 1'b0;
        @(posedge clk); #1;
        $display("S pulse between edges | Q m0=%b", q_m0);
        check("pulse_post_q", q_m0, 0);

        // Multi-bit independence.
        step(1'b1, 1'b0, 1'b0, 4'b1010, 4'b0101);
        check("w4_set_q", q_w4, 4'b1010);
        check("w4_set_inv", inv_w4, 4'b0000);
        step(1'b1, 1'b0, 1'b0, 4'b0011, 4'b0011);
        check("w4_both_q",   q_w4,   4'b1010);
        check("w4_both_inv", inv_w4, 4'b0011);
        check("w4_both_qn",  qn_w4,  4'b0101);
        step(1'b1, 1'b0, 1'b0, 4'b0100, 4'b1000);
        check("w4_mix_q",   q_w4,   4'b0110);
        check("w4_mix_inv", inv_w4, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
